// File: rtl/knn_seq_topk_if.sv
// Handshake bundle for knn_seq_topk: query start, candidate stream, result list.
// Optional res_idx (macro KNN_SEQ_IDX_EN) carries stream index per slot.
interface knn_seq_topk_if #(
  parameter int W = 8,
  parameter int K = 2,
  parameter int N = 16
);
  localparam int DW = $clog2(W + 1);
  localparam int CW = $clog2(N + 1);

  logic            start;
  logic [W-1:0]    query;
  logic            cand_valid;
  logic            cand_ready;
  logic [W-1:0]    cand_data;
  logic            cand_last;
  logic            res_valid;
  logic            res_ready;
  logic [W*K-1:0]  res_val;
  logic [DW*K-1:0] res_dist;
  logic [CW-1:0]   res_cnt;
  logic            busy;
`ifdef KNN_SEQ_IDX_EN
  logic [CW*K-1:0] res_idx;

  modport slave (
    input  start, query, cand_valid,
    input  cand_data, cand_last, res_ready,
    output cand_ready, res_valid, res_val,
    output res_dist, res_cnt, busy, res_idx
  );
  modport master (
    output start, query, cand_valid,
    output cand_data, cand_last, res_ready,
    input  cand_ready, res_valid, res_val,
    input  res_dist, res_cnt, busy, res_idx
  );
`else
  modport slave (
    input  start, query, cand_valid,
    input  cand_data, cand_last, res_ready,
    output cand_ready, res_valid, res_val,
    output res_dist, res_cnt, busy
  );
  modport master (
    output start, query, cand_valid,
    output cand_data, cand_last, res_ready,
    input  cand_ready, res_valid, res_val,
    input  res_dist, res_cnt, busy
  );
`endif
endinterface

// File: rtl/knn_seq_topk.sv
// Sequential Hamming K-nearest-neighbour engine keeping a sorted top-K list.
// Ports: clk, rst_n (async low), bus (knn_seq_topk_if.slave); KNN_SEQ_IDX_EN adds res_idx.
module knn_seq_topk #(
  parameter int W = 8,
  parameter int K = 2,
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst_n,
  knn_seq_topk_if.slave bus
);
  localparam int DW = $clog2(W + 1);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [W-1:0]    r_query;
  logic [W-1:0]    r_val  [K];
  logic [DW-1:0]   r_dist [K];
  logic [K-1:0]    r_vld;
  logic [CW-1:0]   r_cnt;
`ifdef KNN_SEQ_IDX_EN
  logic [CW-1:0]   r_idx  [K];
`endif

  logic            w_acc;
  logic            w_term;
  logic [DW-1:0]   w_d;
  logic [K-1:0]    w_hit;
  logic [K-1:0]    w_pre;
  logic [CW-1:0]   w_fill;

  assign bus.cand_ready = (r_state == S_STREAM);
  assign bus.res_valid  = (r_state == S_DONE);
  assign bus.busy       = (r_state != S_IDLE);

  assign w_acc  = bus.cand_valid & bus.cand_ready;
  assign w_term = w_acc &
    (bus.cand_last | (r_cnt == CW'(N - 1)));

  always_comb begin
    w_d = '0;
    for (int b = 0; b < W; b++)
      w_d = w_d + DW'(r_query[b] ^ bus.cand_data[b]);
  end

  // w_pre[i]: an earlier slot takes the newcomer, so slot i shifts.
  always_comb begin
    w_hit = '0;
    w_pre = '0;
    for (int i = 0; i < K; i++)
      w_hit[i] = !r_vld[i] || (r_dist[i] > w_d);
    for (int i = 1; i < K; i++)
      w_pre[i] = w_pre[i-1] | w_hit[i-1];
  end

  always_comb begin
    w_fill = '0;
    for (int i = 0; i < K; i++)
      w_fill = w_fill + CW'(r_vld[i]);
  end
  assign bus.res_cnt = w_fill;

  for (genvar g = 0; g < K; g++) begin : g_out
    assign bus.res_val[W*g +: W]    = r_val[g];
    assign bus.res_dist[DW*g +: DW] = r_dist[g];
`ifdef KNN_SEQ_IDX_EN
    assign bus.res_idx[CW*g +: CW]  = r_idx[g];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (bus.start) begin
      w_nxt = S_STREAM;
    end else begin
      case (r_state)
        S_STREAM: if (w_term)        w_nxt = S_DONE;
        S_DONE:   if (bus.res_ready) w_nxt = S_IDLE;
        default:  w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_query <= '0;
      r_vld   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < K; i++) begin
        r_val[i]  <= '0;
        r_dist[i] <= '0;
`ifdef KNN_SEQ_IDX_EN
        r_idx[i]  <= '0;
`endif
      end
    end else if (bus.start) begin
      r_query <= bus.query;
      r_vld   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < K; i++) begin
        r_val[i]  <= '0;
        r_dist[i] <= '0;
`ifdef KNN_SEQ_IDX_EN
        r_idx[i]  <= '0;
`endif
      end
    end else if (w_acc) begin
      if (r_cnt != CW'(N))
        r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < K; i++) begin
        if (!w_pre[i] && w_hit[i]) begin
          r_val[i]  <= bus.cand_data;
          r_dist[i] <= w_d;
          r_vld[i]  <= 1'b1;
`ifdef KNN_SEQ_IDX_EN
          r_idx[i]  <= r_cnt;
`endif
        end
      end
      for (int i = 1; i < K; i++) begin
        if (w_pre[i]) begin
          r_val[i]  <= r_val[i-1];
          r_dist[i] <= r_dist[i-1];
          r_vld[i]  <= r_vld[i-1];
`ifdef KNN_SEQ_IDX_EN
          r_idx[i]  <= r_idx[i-1];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_knn_seq_topk.sv
// Directed self-checking bench for knn_seq_topk (W=8, K=2, N=16).
// Inputs change on negedge; outputs are sampled on negedge.
module tb_knn_seq_topk;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  knn_seq_topk_if #(.W(8), .K(2), .N(16)) bus ();

  knn_seq_topk #(.W(8), .K(2), .N(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] q);
    bus.start = 1'b1;
    bus.query = q;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       last
  );
    bus.cand_valid = 1'b1;
    bus.cand_data  = d;
    bus.cand_last  = last;
    @(negedge clk);
    bus.cand_valid = 1'b0;
    bus.cand_last  = 1'b0;
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.query      = '0;
    bus.cand_valid = 1'b0;
    bus.cand_data  = '0;
    bus.cand_last  = 1'b0;
    bus.res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_rdy",   bus.cand_ready, 0);
    chk("rst_rv",    bus.res_valid, 0);
    chk("rst_cnt",   bus.res_cnt, 0);
    chk("rst_val",   bus.res_val, 0);
    chk("rst_dist",  bus.res_dist, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a stream
    do_start(8'h00);
    chk("t1_rdy", bus.cand_ready, 1);
    send(8'hFF, 1'b0);
    chk("t1_cnt_pre", bus.res_cnt, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t1_busy", bus.busy, 0);
    chk("t1_rv",   bus.res_valid, 0);
    chk("t1_rdy2", bus.cand_ready, 0);
    chk("t1_cnt",  bus.res_cnt, 0);

    // Basic sort, d=W insertable
    do_start(8'h00);
    send(8'hFF, 1'b0);
    chk("t2_dmax", bus.res_dist, 64'h08);
    send(8'h03, 1'b0);
    send(8'h01, 1'b0);
    chk("t2_rv_pre", bus.res_valid, 0);
    send(8'h07, 1'b1);
    chk("t2_rv",   bus.res_valid, 1);
    chk("t2_val",  bus.res_val, 64'h0301);
    chk("t2_dist", bus.res_dist, 64'h21);
    chk("t2_cnt",  bus.res_cnt, 2);
    chk("t2_rdy",  bus.cand_ready, 0);
`ifdef KNN_SEQ_IDX_EN
    chk("t2_idx",  bus.res_idx, {5'd1, 5'd2});
`endif
    send(8'h00, 1'b1);
    chk("t2_hold", bus.res_val, 64'h0301);
    take();
    chk("t2_idle", bus.busy, 0);
    chk("t2_rv2",  bus.res_valid, 0);

    // Ties keep arrival order
    do_start(8'h00);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h04, 1'b1);
    chk("t3_val",  bus.res_val, 64'h0201);
    chk("t3_dist", bus.res_dist, 64'h11);
`ifdef KNN_SEQ_IDX_EN
    chk("t3_idx",  bus.res_idx, {5'd1, 5'd0});
`endif
    take();

    // Auto-terminate at N
    do_start(8'hAA);
    for (int i = 0; i < 15; i++) send(8'hAA, 1'b0);
    chk("t4_rv15",  bus.res_valid, 0);
    chk("t4_rdy15", bus.cand_ready, 1);
    send(8'hAA, 1'b0);
    chk("t4_rv",   bus.res_valid, 1);
    chk("t4_rdy",  bus.cand_ready, 0);
    chk("t4_dist", bus.res_dist, 0);
    chk("t4_val",  bus.res_val, 64'hAAAA);
    chk("t4_cnt",  bus.res_cnt, 2);

    // start while DONE with res_ready high
    bus.res_ready = 1'b1;
    do_start(8'h00);
    bus.res_ready = 1'b0;
    chk("t6_rv",   bus.res_valid, 0);
    chk("t6_rdy",  bus.cand_ready, 1);
    chk("t6_cnt",  bus.res_cnt, 0);
    chk("t6_val",  bus.res_val, 0);
    send(8'h01, 1'b1);
    chk("t6_dist", bus.res_dist, 64'h01);
    chk("t6_val2", bus.res_val, 64'h0001);
    take();

    // Single candidate, fewer than K
    do_start(8'h00);
    send(8'h0F, 1'b1);
    chk("t5_rv",   bus.res_valid, 1);
    chk("t5_cnt",  bus.res_cnt, 1);
    chk("t5_val",  bus.res_val, 64'h000F);
    chk("t5_dist", bus.res_dist, 64'h04);
`ifdef KNN_SEQ_IDX_EN
    chk("t5_idx",  bus.res_idx, 0);
`endif
    take();
    chk("t5_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
